// File: rtl/shapool_pkg.sv
// shapool_pkg: definitions shared by the shapool pool and its result stage.
//   - pool_state_t : controller state encoding
//   - NW           : width of the per-unit nonce counter for the default pool
//   - nonce_width(): per-unit nonce width for an arbitrary pool size
package shapool_pkg;

  localparam int POOL_SIZE_LOG2_DEFAULT = 1;
  localparam int NW = 32 - POOL_SIZE_LOG2_DEFAULT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } pool_state_t;

  // Each unit counts only the low bits. The top log2(units) bits of the
  // full nonce are replaced by the unit index.
  function automatic int nonce_width(input int pool_size_log2);
    return 32 - pool_size_log2;
  endfunction

endpackage

// File: rtl/shapool_prio_enc.sv
// shapool_prio_enc: lowest-set-bit encoder.
//   flags [POOL_SIZE-1:0]      in  : request vector
//   idx   [POOL_SIZE_LOG2-1:0] out : index of the lowest set bit (0 if none)
module shapool_prio_enc #(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1
) (
  input  logic [POOL_SIZE-1:0]      flags,
  output logic [POOL_SIZE_LOG2-1:0] idx
);

  // Scan from the top down so that the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--) begin
      if (flags[i]) idx = POOL_SIZE_LOG2'(i);
    end
  end

endmodule

// File: rtl/shapool_result.sv
// shapool_result: result collector and lifecycle controller for the shapool
// hashing pool.
//   clk, reset_n          : clock, asynchronous active-low reset
//   job_start             : pulse; clear state and (re)start the pool
//   nonce_start_MSB[7:0]  : job start MSBs, sampled on job_start
//   pool_success          : pool success pulse
//   pool_nonce[31:0]      : pool nonce (upper POOL_SIZE_LOG2 bits are zero)
//   pool_match_flags      : per-unit match flags
//   pool_reset_n          : registered reset to the pool
//   result_valid/ready    : single-entry result handshake
//   result_nonce[31:0]    : reconstructed winning nonce
//   result_flags          : match flags captured with the result
//   result_dropped        : sticky, a success arrived while the register was full
//   busy                  : pool running or draining
//   exhausted             : nonce space finished for this job
module shapool_result
  import shapool_pkg::*;
#(
  parameter int POOL_SIZE      = 2,
  parameter int POOL_SIZE_LOG2 = 1,
  parameter int NONCE_LAG      = 2,
  parameter int ROUNDS         = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 job_start,
  input  logic [7:0]           nonce_start_MSB,
  input  logic                 pool_success,
  input  logic [31:0]          pool_nonce,
  input  logic [POOL_SIZE-1:0] pool_match_flags,
  output logic                 pool_reset_n,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [31:0]          result_nonce,
  output logic [POOL_SIZE-1:0] result_flags,
  output logic                 result_dropped,
  output logic                 busy,
  output logic                 exhausted
);

  localparam int LW           = nonce_width(POOL_SIZE_LOG2);
  localparam int DRAIN_CYCLES = NONCE_LAG * ROUNDS;
  localparam int CW           = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [LW-1:0] LAG        = LW'(NONCE_LAG);

  pool_state_t state_reg, state_next;

  logic [CW-1:0]             drain_cnt_reg;
  logic [7:0]                start_msb_q;
  logic [LW-1:0]             prev_lower;
  logic [LW-1:0]             lower;
  logic [LW-1:0]             corr;
  logic [POOL_SIZE_LOG2-1:0] win_idx;
  logic [31:0]               nonce_next;
  logic                      lower_wrap;
  logic                      capture;
  logic                      xfer;

  assign lower = pool_nonce[LW-1:0];
  // The pool reports a success NONCE_LAG increments after the winning nonce
  // entered it; wrap-around modulo 2^LW is intended.
  assign corr  = lower - LAG;

  shapool_prio_enc #(
    .POOL_SIZE      (POOL_SIZE),
    .POOL_SIZE_LOG2 (POOL_SIZE_LOG2)
  ) u_prio_enc (
    .flags (pool_match_flags),
    .idx   (win_idx)
  );

  // The pool counts from start_msb XOR'ed into the top byte of its counter,
  // so undo that here and prepend the winning unit's index.
  assign nonce_next = {win_idx, corr[LW-1:LW-8] ^ start_msb_q, corr[LW-9:0]};

  assign lower_wrap = (&prev_lower) && (lower == '0);
  assign xfer       = result_valid && result_ready;
  // A job_start in the same cycle wins: the capture belongs to the old job.
  assign capture    = busy && pool_success && (|pool_match_flags) && !job_start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (job_start) begin
      state_next = ST_ARM;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_IDLE;
        ST_ARM:   state_next = ST_RUN;
        ST_RUN:   if (lower_wrap) state_next = ST_DRAIN;
        ST_DRAIN: if (drain_cnt_reg == '0) state_next = ST_DONE;
        ST_DONE:  state_next = ST_DONE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy      = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    exhausted = (state_reg == ST_DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pool_reset_n   <= 1'b0;
      drain_cnt_reg  <= '0;
      start_msb_q    <= '0;
      prev_lower     <= '0;
      result_valid   <= 1'b0;
      result_nonce   <= '0;
      result_flags   <= '0;
      result_dropped <= 1'b0;
    end else begin
      // Registered from the next state so the pool leaves reset exactly at
      // the ARM->RUN edge and is re-held on the edge into ARM/DONE.
      pool_reset_n <= (state_next == ST_RUN) || (state_next == ST_DRAIN);

      if (job_start) start_msb_q <= nonce_start_MSB;

      // Cleared on ARM so a stale all-ones value from an aborted job cannot
      // fake a wrap against the freshly reset pool counter.
      if (state_reg == ST_ARM)      prev_lower <= '0;
      else if (state_reg == ST_RUN) prev_lower <= lower;

      if (state_reg == ST_RUN && lower_wrap)
        drain_cnt_reg <= DRAIN_LOAD;
      else if (state_reg == ST_DRAIN && drain_cnt_reg != '0)
        drain_cnt_reg <= drain_cnt_reg - 1'b1;

      if (job_start || state_reg == ST_ARM) begin
        result_valid   <= 1'b0;
        result_dropped <= 1'b0;
      end else if (capture) begin
        if (!result_valid || xfer) begin
          result_valid <= 1'b1;
          result_nonce <= nonce_next;
          result_flags <= pool_match_flags;
        end else begin
          result_dropped <= 1'b1;
        end
      end else if (xfer) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shapool_result.sv
module tb_shapool_result;

  logic        clk;
  logic        reset_n;
  logic        job_start;
  logic [7:0]  nonce_start_MSB;
  logic        pool_success;
  logic [31:0] pool_nonce;
  logic [1:0]  pool_match_flags;
  logic        pool_reset_n;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_nonce;
  logic [1:0]  result_flags;
  logic        result_dropped;
  logic        busy;
  logic        exhausted;

  int checks;
  int errors;

  shapool_result #(
    .POOL_SIZE      (2),
    .POOL_SIZE_LOG2 (1),
    .NONCE_LAG      (2),
    .ROUNDS         (64)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .job_start        (job_start),
    .nonce_start_MSB  (nonce_start_MSB),
    .pool_success     (pool_success),
    .pool_nonce       (pool_nonce),
    .pool_match_flags (pool_match_flags),
    .pool_reset_n     (pool_reset_n),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_nonce     (result_nonce),
    .result_flags     (result_flags),
    .result_dropped   (result_dropped),
    .busy             (busy),
    .exhausted        (exhausted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture_in(input logic [31:0] n, input logic [1:0] f);
    pool_nonce       = n;
    pool_match_flags = f;
    pool_success     = 1'b1;
    step();
    pool_success     = 1'b0;
    pool_match_flags = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n          = 1'b0;
    job_start        = 1'b0;
    nonce_start_MSB  = 8'h00;
    pool_success     = 1'b0;
    pool_nonce       = 32'h0;
    pool_match_flags = 2'b00;
    result_ready     = 1'b0;

    step();
    step();
    chk("rst_pool_reset_n", pool_reset_n, 0);
    chk("rst_valid",        result_valid, 0);
    chk("rst_busy",         busy, 0);
    chk("rst_exhausted",    exhausted, 0);
    chk("rst_nonce",        result_nonce, 0);
    reset_n = 1'b1;
    step();
    chk("idle_pool_reset_n", pool_reset_n, 0);

    // ---- job 1, MSB 0xA5 ----
    nonce_start_MSB = 8'hA5;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    chk("arm1_pool_reset_n", pool_reset_n, 0);
    chk("arm1_busy",         busy, 0);
    step();
    chk("run1_pool_reset_n", pool_reset_n, 1);
    chk("run1_busy",         busy, 1);

    capture_in(32'h0000_0012, 2'b10);
    chk("cap1_valid", result_valid, 1);
    chk("cap1_nonce", result_nonce, 32'hD280_0010);
    chk("cap1_flags", result_flags, 2'b10);

    // Full register, host not ready: new result is dropped.
    capture_in(32'h0000_0001, 2'b11);
    chk("drop_valid",   result_valid, 1);
    chk("drop_nonce",   result_nonce, 32'hD280_0010);
    chk("drop_flag",    result_dropped, 1);

    // Capture and transfer in the same cycle: new result replaces old.
    result_ready = 1'b1;
    capture_in(32'h0000_0001, 2'b11);
    chk("xcap_valid", result_valid, 1);
    chk("xcap_nonce", result_nonce, 32'h2D7F_FFFF);
    chk("xcap_flags", result_flags, 2'b11);

    // Plain transfer.
    step();
    chk("xfer_valid", result_valid, 0);
    result_ready = 1'b0;

    // Success with no match flag is ignored.
    capture_in(32'h0000_0040, 2'b00);
    chk("noflag_valid", result_valid, 0);

    // Leave a result pending, then restart the job while running.
    capture_in(32'h0000_0001, 2'b11);
    chk("pend_valid", result_valid, 1);
    nonce_start_MSB = 8'h00;
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    chk("arm2_valid",        result_valid, 0);
    chk("arm2_dropped",      result_dropped, 0);
    chk("arm2_pool_reset_n", pool_reset_n, 0);
    step();
    chk("run2_pool_reset_n", pool_reset_n, 1);

    // Lag correction wraps below zero; unit 0 wins over unit 1.
    capture_in(32'h0000_0001, 2'b11);
    chk("wrap_nonce", result_nonce, 32'h7FFF_FFFF);
    chk("wrap_flags", result_flags, 2'b11);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("wrap_xfer_valid", result_valid, 0);

    // ---- exhaustion ----
    pool_nonce = 32'h7FFF_FFFF;
    step();
    chk("prewrap_busy", busy, 1);
    pool_nonce = 32'h0000_0000;
    step();
    // Now in DRAIN, first cycle.
    chk("drain_busy",      busy, 1);
    chk("drain_exhausted", exhausted, 0);
    chk("drain_pool_rst",  pool_reset_n, 1);
    capture_in(32'h0000_0005, 2'b01);
    chk("drain_cap_valid", result_valid, 1);
    chk("drain_cap_nonce", result_nonce, 32'h0000_0003);
    pool_nonce = 32'h0000_0000;
    for (int i = 0; i < 126; i++) step();
    // Last DRAIN cycle (128th).
    chk("drain_last_busy",      busy, 1);
    chk("drain_last_exhausted", exhausted, 0);
    step();
    chk("done_exhausted",  exhausted, 1);
    chk("done_busy",       busy, 0);
    chk("done_pool_rst",   pool_reset_n, 0);
    step();
    chk("done_hold",       exhausted, 1);

    // ---- job 3: restart from DONE, abort during DRAIN ----
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    chk("arm3_exhausted", exhausted, 0);
    chk("arm3_valid",     result_valid, 0);
    step();
    pool_nonce = 32'h7FFF_FFFF;
    step();
    pool_nonce = 32'h0000_0000;
    step();
    chk("drain3_busy", busy, 1);
    capture_in(32'h0000_0005, 2'b01);
    chk("drain3_valid", result_valid, 1);
    job_start = 1'b1;
    step();
    job_start = 1'b0;
    chk("abort_pool_rst",  pool_reset_n, 0);
    chk("abort_exhausted", exhausted, 0);
    chk("abort_valid",     result_valid, 0);
    chk("abort_busy",      busy, 0);
    step();
    chk("rerun_pool_rst",  pool_reset_n, 1);
    chk("rerun_busy",      busy, 1);

    // ---- asynchronous reset in RUN with a result pending ----
    capture_in(32'h0000_0012, 2'b10);
    chk("prerst_valid", result_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_pool_rst", pool_reset_n, 0);
    chk("arst_valid",    result_valid, 0);
    chk("arst_busy",     busy, 0);
    chk("arst_nonce",    result_nonce, 0);
    chk("arst_flags",    result_flags, 0);
    chk("arst_exhausted", exhausted, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_pool_rst", pool_reset_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shapool_result.md
Name: shapool_result

Overview:
- Sits directly downstream of the shapool hashing pool and also owns the pool's reset.
- Arms the pool for each job and watches its per-round success/match outputs.
- Rebuilds the full 32-bit winning nonce (unit index, lag correction, start-MSB XOR) and presents it to the host through a single-entry valid/ready register.
- Detects nonce-space exhaustion, drains in-flight hashes, then parks the pool.

Parameters:
- POOL_SIZE, 2, number of hashing units; must be a power of 2.
- POOL_SIZE_LOG2, 1, log2(POOL_SIZE); must be >0.
- NONCE_LAG, 2, nonce increments between a nonce entering the pool and its success report.
- ROUNDS, 64, clocks per hash period.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- job_start  in  1  one-cycle pulse: clear state and (re)start the pool
- nonce_start_MSB  in  8  job start MSBs; sampled on job_start
- pool_success  in  1  pool success pulse
- pool_nonce  in  32  pool nonce output; upper POOL_SIZE_LOG2 bits are zero
- pool_match_flags  in  POOL_SIZE  per-unit match flags
- pool_reset_n  out  1  registered, synchronous reset to the pool
- result_valid  out  1  result register holds an unread result
- result_ready  in  1  host accepts the result
- result_nonce  out  32  reconstructed winning nonce
- result_flags  out  POOL_SIZE  all match flags captured with the result
- result_dropped  out  1  sticky: a success arrived while the result register was full
- busy  out  1  pool running or draining
- exhausted  out  1  nonce space finished for this job

Behaviour:
- Reset values (async, while reset_n=0):
  - State IDLE; pool_reset_n=0; all other outputs 0.
  - Internal registers cleared, including start_msb_q and prev_lower.
- Definitions:
  - NW = 32 - POOL_SIZE_LOG2.
  - lower = pool_nonce[NW-1:0].
- States:
  - IDLE: pool_reset_n=0. job_start -> ARM.
  - ARM: one cycle. pool_reset_n=0, latch start_msb_q, clear result_valid/result_dropped/exhausted. Next state RUN; pool_reset_n goes 1 at the ARM->RUN edge.
  - RUN: busy=1, pool_reset_n=1. On a lower wrap (prev_lower all-ones and lower==0): load drain counter with NONCE_LAG*ROUNDS-1 and go to DRAIN.
  - DRAIN: busy=1, successes still captured. Decrement each cycle; at 0 go to DONE.
  - DONE: pool_reset_n=0, busy=0, exhausted=1. Hold until job_start.
- job_start in any state (including RUN, DRAIN, or a pending result) goes to ARM and discards the pending result.
- Capture, only in RUN/DRAIN with pool_success=1 and |pool_match_flags:
  - corr = lower - NONCE_LAG, modulo 2^NW.
  - idx = lowest set bit index of pool_match_flags.
  - result_nonce = {idx, corr[NW-1:NW-8]^start_msb_q, corr[NW-9:0]}.
  - result_flags = pool_match_flags; result_valid=1 on the next cycle.
- Handshake:
  - A transfer occurs when result_valid && result_ready. result_valid falls the next cycle unless a new capture happens.
  - Capture with result_valid=1 and no transfer in that cycle: the new result is dropped and result_dropped=1 (sticky until ARM).
  - Capture and transfer in the same cycle: the new result is loaded and result_valid stays 1.
  - Outputs stay stable while result_valid && !result_ready.
- Latency: pool_success to result_valid is 1 clock.
- pool_success with pool_match_flags==0 is ignored.
- prev_lower updates every cycle in RUN.

Decomposition:
- Package shapool_pkg holds NW and state encodings, shared with shapool.
- One sub-module: shapool_prio_enc. It is a parameterised lowest-set-bit encoder, POOL_SIZE -> POOL_SIZE_LOG2 bits.

Test Plan:
- Reset mid-run (reset_n low in RUN) -> all outputs 0, pool_reset_n=0 immediately.
- job_start with nonce_start_MSB=0xA5, then pool_nonce=0x00000012, flags=2'b10, success -> one clock later result_valid=1, result_nonce=0xD2800010, result_flags=2'b10.
- Capture with pool_nonce=0x00000001, flags=2'b11, MSB=0x00 -> result_nonce=0x7FFFFFFF (lag wrap, unit 0 wins).
- Success with result_ready=0 and result pending -> result_nonce unchanged, result_dropped=1.
- Success and result_ready=1 in the same cycle -> new result loaded, result_valid stays 1.
- pool_nonce lower goes 0x7FFFFFFF -> 0 -> DRAIN for 128 cycles (a success during DRAIN is captured), then exhausted=1, busy=0, pool_reset_n=0.
- job_start during DRAIN -> ARM (pool_reset_n=0 for 1 cycle), exhausted=0, result_valid=0.
